// File: rtl/irq_pending_ctrl_pkg.sv
// Shared sizes and FSM state encoding for the interrupt pending/offer path.
package irq_pending_ctrl_pkg;

  localparam int IRQ_N   = 8;
  localparam int IRQ_IDW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/irq_pending_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder: reports the index of the lowest set bit
// and whether any bit is set.
module prio_enc_lsb
  import irq_pending_ctrl_pkg::*;
#(
  parameter int N   = IRQ_N,
  parameter int IDW = IRQ_IDW
) (
  input  logic [N-1:0]   vec,
  input  logic           unused_tie,
  output logic [IDW-1:0] id,
  output logic           any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    id  = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        id  = IDW'(i);
        any = 1'b1;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = unused_tie;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Request capture, pending/overflow tracking and single-id offer handshake
// feeding the downstream 8-to-3 priority path.
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
#(
  parameter int N    = IRQ_N,
  parameter int IDW  = IRQ_IDW,
  parameter int EDGE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  input  logic           ack,
  input  logic           clr_ovf,
  output logic           irq_valid,
  output logic [IDW-1:0] irq_id,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   ovf
);

  state_t         state_q;
  state_t         state_n;
  logic [N-1:0]   req_q;
  logic           arm;
  logic [N-1:0]   ev;
  logic [N-1:0]   clr_vec;
  logic [N-1:0]   pending_n;
  logic [N-1:0]   ovf_n;
  logic [N-1:0]   elig;
  logic [IDW-1:0] sel;
  logic           any_elig;
  logic           ack_fire;
  logic           id_load;

  // Edge mode: the first cycle after reset only establishes the baseline of
  // req levels, so lines held high through reset do not look like new edges.
  assign ev = (EDGE != 0) ? (req & ~req_q & {N{arm}}) : req;

  // Ack only counts while an id is actually being offered.
  assign ack_fire = (state_q == OFFER) && ack;
  assign clr_vec  = ack_fire ? (N'(1) << irq_id) : '0;

  // A new event wins over the ack-clear of the same bit; overflow is only
  // raised when the bit was pending and is not being retired on this edge.
  always_comb begin
    pending_n = (pending & ~clr_vec) | ev;
    ovf_n     = (clr_ovf ? '0 : ovf) | (ev & pending & ~clr_vec);
  end

  assign elig = pending & ~mask;

  prio_enc_lsb #(
    .N   (N),
    .IDW (IDW)
  ) u_enc (
    .vec        (elig),
    .unused_tie (1'b0),
    .id         (sel),
    .any        (any_elig)
  );

  // Request history, pending and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      arm     <= 1'b0;
      pending <= '0;
      ovf     <= '0;
    end else begin
      req_q   <= req;
      arm     <= 1'b1;
      pending <= pending_n;
      ovf     <= ovf_n;
    end
  end

  // FSM state register and the latched offered id.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      irq_id  <= '0;
    end else begin
      state_q <= state_n;
      if (id_load) begin
        irq_id <= sel;
      end
    end
  end

  // Next-state: latch the winner from IDLE, hold it until ack, then one gap.
  always_comb begin
    state_n = state_q;
    id_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          id_load = 1'b1;
          state_n = OFFER;
        end
      end
      OFFER: begin
        if (ack) begin
          state_n = GAP;
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign irq_valid = (state_q == OFFER);

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Randomized and scenario-driven bench for irq_pending_ctrl with a behavioural
// reference model and a cycle-by-cycle expectation queue.
module tb_irq_pending_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;
  logic       clr_ovf;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic [7:0] ovf;

  irq_pending_ctrl #(
    .N    (8),
    .IDW  (3),
    .EDGE (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mask      (mask),
    .ack       (ack),
    .clr_ovf   (clr_ovf),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pend;
    logic [7:0] ovf;
    logic       valid;
    logic [2:0] id;
    logic       chk_id;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit m_pend[8];
  bit m_ovf[8];
  bit m_reqq[8];
  bit m_baseline_done;
  bit m_offering;
  bit m_in_gap;
  int m_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
  endtask

  // Apply the rules to the inputs sampled at this edge and queue the outcome.
  task automatic model_edge();
    bit   n_pend[8];
    bit   n_ovf[8];
    bit   ack_taken;
    bit   event_i;
    bit   retire;
    exp_t e;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_pend[i] = 0; m_ovf[i] = 0; m_reqq[i] = 0;
      end
      m_baseline_done = 0;
      m_offering = 0;
      m_in_gap = 0;
      m_id = 0;
    end else begin
      ack_taken = m_offering && ack;
      for (int i = 0; i < 8; i++) begin
        event_i = req[i] && !m_reqq[i] && m_baseline_done;
        retire  = ack_taken && (i == m_id);
        n_pend[i] = event_i ? 1'b1 : (retire ? 1'b0 : m_pend[i]);
        n_ovf[i]  = (clr_ovf ? 1'b0 : m_ovf[i]) || (event_i && m_pend[i] && !retire);
      end
      if (m_offering) begin
        if (ack_taken) begin
          m_offering = 0;
          m_in_gap = 1;
        end
      end else if (m_in_gap) begin
        m_in_gap = 0;
      end else begin
        for (int i = 7; i >= 0; i--) begin
          if (m_pend[i] && !mask[i]) begin
            m_offering = 1;
            m_id = i;
          end
        end
      end
      for (int i = 0; i < 8; i++) begin
        m_pend[i] = n_pend[i];
        m_ovf[i]  = n_ovf[i];
        m_reqq[i] = req[i];
      end
      m_baseline_done = 1;
    end
    for (int i = 0; i < 8; i++) begin
      e.pend[i] = m_pend[i];
      e.ovf[i]  = m_ovf[i];
    end
    e.valid  = m_offering;
    e.id     = 3'(m_id);
    e.chk_id = m_offering || rst;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input logic r, input logic [7:0] rq,
                     input logic [7:0] mk, input logic a, input logic co);
    for (int k = 0; k < n; k++) begin
      rst = r; req = rq; mask = mk; ack = a; clr_ovf = co;
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare with the oldest
  // queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pending", 32'(pending), 32'(e.pend));
      check("ovf", 32'(ovf), 32'(e.ovf));
      check("irq_valid", 32'(irq_valid), 32'(e.valid));
      if (e.chk_id) check("irq_id", 32'(irq_id), 32'(e.id));
    end
  end

  initial begin
    rst = 1'b0; req = '0; mask = '0; ack = 1'b0; clr_ovf = 1'b0;
    m_baseline_done = 0; m_offering = 0; m_in_gap = 0; m_id = 0;
    for (int i = 0; i < 8; i++) begin
      m_pend[i] = 0; m_ovf[i] = 0; m_reqq[i] = 0;
    end
    #2;
    // Reset with all requests high, then keep them high after release
    run(2, 1, 8'hFF, 8'h00, 0, 0);
    run(3, 0, 8'hFF, 8'h00, 0, 0);
    run(2, 0, 8'h00, 8'h00, 0, 0);
    // Single request on bit 5, then ack
    run(1, 0, 8'h20, 8'h00, 0, 0);
    run(3, 0, 8'h20, 8'h00, 0, 0);
    run(1, 0, 8'h00, 8'h00, 1, 0);
    run(2, 0, 8'h00, 8'h00, 0, 0);
    // Simultaneous requests 3,4,5 with ack held high
    run(1, 0, 8'h38, 8'h00, 0, 0);
    run(12, 0, 8'h00, 8'h00, 1, 0);
    // Masking bit 3, then unmask during the offer of id 4
    run(1, 0, 8'h38, 8'h08, 0, 0);
    run(3, 0, 8'h00, 8'h08, 0, 0);
    run(2, 0, 8'h00, 8'h00, 0, 0);
    run(12, 0, 8'h00, 8'h00, 1, 0);
    // Overflow on bit 2, clear, then edge coinciding with ack of bit 2
    run(1, 0, 8'h04, 8'h00, 0, 0);
    run(1, 0, 8'h00, 8'h00, 0, 0);
    run(1, 0, 8'h04, 8'h00, 0, 0);
    run(2, 0, 8'h00, 8'h00, 0, 0);
    run(1, 0, 8'h00, 8'h00, 0, 1);
    run(2, 0, 8'h00, 8'h00, 0, 0);
    run(1, 0, 8'h04, 8'h00, 1, 0);
    run(3, 0, 8'h00, 8'h00, 0, 0);
    run(4, 0, 8'h00, 8'h00, 1, 0);
    // Reset while id 6 is offered, then a stray ack
    run(1, 0, 8'h40, 8'h00, 0, 0);
    run(2, 0, 8'h00, 8'h00, 0, 0);
    run(1, 1, 8'h00, 8'h00, 0, 0);
    run(1, 0, 8'h00, 8'h00, 1, 0);
    run(2, 0, 8'h00, 8'h00, 0, 0);
    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] rq;
      logic [7:0] mk;
      rq = 8'($urandom) & 8'($urandom) & 8'($urandom);
      mk = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      run(1, ($urandom_range(0, 199) == 0), rq, mk,
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0));
    end
    run(1, 0, 8'h00, 8'h00, 0, 0);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
